mb_cam_ctl: RTL and testbench
=============================

MB_CAM_CTL -- requirements
Module: mb_cam_ctl

Interface
REQ-001 SHALL have parameter: INIT_DATA, 40'h0, value written to every CAM entry during the INIT sweep.
REQ-002 SHALL have port: rclk  in  1  sole clock, all flops rising edge.
REQ-003 SHALL have port: rst_l  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports: alloc_req in 1, alloc_din in 40, alloc_gnt out 1, alloc_idx out 4  insert entry, returns slot.
REQ-005 SHALL have ports: dealloc_vld in 1, dealloc_idx in 4  free slot.
REQ-006 SHALL have ports: rd_req in 1, rd_idx in 4, rd_gnt out 1, rd_vld out 1, rd_data out 40  indexed read.
REQ-007 SHALL have ports: lk_req in 1, lk_key in [39:8], lk_gnt out 1, lk_vld out 1, lk_hit out 1, lk_hit_idx out 4, lk_multi out 1  associative lookup.
REQ-008 SHALL have ports: full out 1, busy out 1  status.
REQ-009 SHALL have CAM-side ports: cam_write_en out 1, cam_adr_w out 16, cam_din out 40, cam_read_en out 1, cam_adr_r out 16, cam_lookup_en out 1, cam_key out [39:8], cam_dout in 40, cam_match in 16.

Function
REQ-010 SHALL run FSM INIT -> RUN; INIT drives writes of INIT_DATA to entries 0..15 (4-bit counter, one per cycle, one-hot cam_adr_w), then moves to RUN after entry 15; busy=1 only in INIT; all grants are 0 in INIT.
REQ-011 SHALL keep a 16-bit valid vector; full = &valid.
REQ-012 SHALL grant alloc when alloc_req & ~full & RUN; slot = lowest-index invalid entry; same cycle: cam_write_en=1, cam_adr_w=one-hot(slot), cam_din=alloc_din, alloc_idx=slot; valid[slot] set at the end of that cycle.
REQ-013 SHALL clear valid[dealloc_idx] at the end of a cycle with dealloc_vld; the freed slot becomes allocatable the following cycle; dealloc of an invalid slot is a no-op.
REQ-014 SHALL grant a read when rd_req & RUN and not (write granted this cycle & rd_idx == write slot); grant drives cam_read_en=1, cam_adr_r=one-hot(rd_idx); cam_dout is registered at the end of cycle N+1; rd_vld=1 and rd_data are presented in cycle N+2 for grant cycle N.
REQ-015 SHALL grant a lookup when lk_req & RUN and no write is granted that cycle (see REQ-021 for the override); grant drives cam_lookup_en=1, cam_key=lk_key.
REQ-016 SHALL qualify cam_match in cycle N+1 with the valid vector current in N+1; in N+2: lk_vld=1, lk_hit=|qualified, lk_hit_idx=lowest set bit (0 if none), lk_multi=1 if >1 bit set.
REQ-017 SHALL never drive a CAM read and write to the same entry, nor a lookup while any entry is written, so CAM X outputs are never sampled.
REQ-018 SHALL keep cam_adr_w/cam_adr_r at 16'h0 and data/key at 0 when the matching enable is 0.
REQ-019 SHALL allow alloc, read (non-conflicting) and dealloc to be granted in the same cycle; grants are combinational from requests and state.

Reset
REQ-020 SHALL, on rst_l low at any time, asynchronously clear valid, the counter, and the rd/lk pipeline valids; set FSM=INIT; drive all outputs to 0 except busy=1; in-flight reads and lookups are dropped without rd_vld/lk_vld.

Configuration
REQ-021 SHALL, with MB_CAM_CTL_LKBYP_EN defined, grant lookups during writes and, in N+1, replace match bit [slot] with (registered cam_din[39:8] == registered key) & valid[slot]; without the macro, lookups stall while any write is granted.

Structure
REQ-022 SHALL place entry count (16), index width (4), data width (40), key range [39:8], FSM state encoding and the one-hot/priority-encode functions in shared package mb_cam_pkg.
REQ-023 SHALL instantiate one sub-module, mb_cam_penc (16-bit lowest-set priority encoder with any/multi flags), used for both the free-slot search and hit encoding.

Verification
REQ-024 SHALL: reset release -> busy=1 for 16 cycles, cam_adr_w walks 16'h0001..16'h8000 with cam_din=0, then busy=0.
REQ-025 SHALL: 16 back-to-back allocs -> alloc_idx 0..15, full=1 after the 16th; 17th alloc_req -> alloc_gnt=0.
REQ-026 SHALL: dealloc idx 5 while full, alloc next cycle -> alloc_idx=5, full=0 for exactly one cycle.
REQ-027 SHALL: alloc to slot 3 with rd_req rd_idx=3 in the same cycle -> rd_gnt=0; retry next cycle -> rd_vld two cycles later with rd_data = written value.
REQ-028 SHALL: entries 2 and 7 both hold key 32'hDEADBEEF, lookup -> lk_hit=1, lk_hit_idx=2, lk_multi=1; with entry 2 deallocated -> lk_hit_idx=7, lk_multi=0.
REQ-029 SHALL: lookup concurrent with alloc of a matching key -> lk_gnt=0 without MB_CAM_CTL_LKBYP_EN; lk_gnt=1 and lk_hit_idx = new slot with the macro.

Source files
------------

// File: rtl/mb_cam_pkg.sv
// Shared definitions for the CAM controller: geometry, key field range,
// controller state encoding and the one-hot / priority-encode helpers.
package mb_cam_pkg;

  localparam int N_ENT  = 16;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 40;
  localparam int KEY_HI = 39;
  localparam int KEY_LO = 8;
  localparam int KEY_W  = KEY_HI - KEY_LO + 1;

  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [N_ENT-1:0]    vec_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [KEY_HI:KEY_LO] key_t;

  // INIT sweeps every entry once, RUN serves requests.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entry index to one-hot CAM row select.
  function automatic vec_t onehot(input idx_t idx);
    vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Index of the lowest set bit, 0 when no bit is set.
  function automatic idx_t prio_lowest(input vec_t v);
    idx_t r;
    r = '0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (v[i]) r = idx_t'(i);
    end
    return r;
  endfunction

  // True when more than one bit is set (clearing the lowest leaves something).
  function automatic logic multi_set(input vec_t v);
    return (v & (v - vec_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/mb_cam_ctl_if.sv
// Client-side bus of the CAM controller: allocate, free, indexed read,
// associative lookup and status. master = client, slave = controller.
interface mb_cam_ctl_if;
  import mb_cam_pkg::*;

  logic  alloc_req;
  data_t alloc_din;
  logic  alloc_gnt;
  idx_t  alloc_idx;

  logic  dealloc_vld;
  idx_t  dealloc_idx;

  logic  rd_req;
  idx_t  rd_idx;
  logic  rd_gnt;
  logic  rd_vld;
  data_t rd_data;

  logic  lk_req;
  key_t  lk_key;
  logic  lk_gnt;
  logic  lk_vld;
  logic  lk_hit;
  idx_t  lk_hit_idx;
  logic  lk_multi;

  logic  full;
  logic  busy;

  modport master (
    output alloc_req, alloc_din, dealloc_vld, dealloc_idx,
           rd_req, rd_idx, lk_req, lk_key,
    input  alloc_gnt, alloc_idx, rd_gnt, rd_vld, rd_data,
           lk_gnt, lk_vld, lk_hit, lk_hit_idx, lk_multi, full, busy
  );

  modport slave (
    input  alloc_req, alloc_din, dealloc_vld, dealloc_idx,
           rd_req, rd_idx, lk_req, lk_key,
    output alloc_gnt, alloc_idx, rd_gnt, rd_vld, rd_data,
           lk_gnt, lk_vld, lk_hit, lk_hit_idx, lk_multi, full, busy
  );

endinterface

// File: rtl/mb_cam_penc.sv
// 16-bit lowest-set-bit priority encoder with any / multi flags.
// Used both to pick the free slot and to encode lookup hits.
module mb_cam_penc
  import mb_cam_pkg::*;
(
  input  vec_t vec,
  output logic any,
  output idx_t idx,
  output logic multi
);

  // Pure combinational encode of the input vector.
  always_comb begin
    any   = |vec;
    idx   = prio_lowest(vec);
    multi = multi_set(vec);
  end

endmodule

// File: rtl/mb_cam_ctl.sv
// Controller in front of a 16x40 CAM macro with registered read/match outputs.
// After reset it writes INIT_DATA to every entry, then tracks entry validity,
// grants allocs (lowest free slot), deallocs, indexed reads and lookups, and
// keeps CAM reads/lookups away from entries being written in the same cycle.
// Optional feature: define MB_CAM_CTL_LKBYP_EN to let lookups proceed while an
// alloc writes, with the written entry's match bit recomputed from the
// captured write data instead of the (unreliable) CAM output.
module mb_cam_ctl
  import mb_cam_pkg::*;
#(
  parameter logic [39:0] INIT_DATA = 40'h0
)
(
  input  logic rclk,
  input  logic rst_l,
  mb_cam_ctl_if.slave cl,
  output logic cam_write_en,
  output vec_t cam_adr_w,
  output data_t cam_din,
  output logic cam_read_en,
  output vec_t cam_adr_r,
  output logic cam_lookup_en,
  output key_t cam_key,
  input  data_t cam_dout,
  input  vec_t cam_match
);

  state_t state_reg, state_next;
  idx_t   init_cnt_reg, init_cnt_next;
  vec_t   valid_reg, valid_next;

  logic   is_run;
  logic   init_wr;

  vec_t   free_vec;
  logic   free_any;
  idx_t   free_idx;
  logic   free_multi_unused;

  logic   alloc_gnt;
  logic   rd_gnt;
  logic   lk_gnt;

  logic   rd_p1_reg;
  logic   rd_vld_reg;
  data_t  rd_data_reg;

  logic   lk_p1_reg;
  logic   lk_vld_reg;
  logic   lk_hit_reg;
  idx_t   lk_hit_idx_reg;
  logic   lk_multi_reg;

  vec_t   qual_match;
  logic   hit_any;
  idx_t   hit_idx;
  logic   hit_multi;

`ifdef MB_CAM_CTL_LKBYP_EN
  logic   byp_vld_reg;
  idx_t   byp_slot_reg;
  key_t   byp_key_reg;
  key_t   lk_key_reg;
`endif

  assign free_vec = ~valid_reg;

  mb_cam_penc u_free_enc (
    .vec   (free_vec),
    .any   (free_any),
    .idx   (free_idx),
    .multi (free_multi_unused)
  );

  mb_cam_penc u_hit_enc (
    .vec   (qual_match),
    .any   (hit_any),
    .idx   (hit_idx),
    .multi (hit_multi)
  );

  // State register, INIT sweep counter and entry valid bits.
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
      valid_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      valid_reg    <= valid_next;
    end
  end

  // Next state: leave INIT once the last entry has been written.
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    if (state_reg == ST_INIT) begin
      init_cnt_next = init_cnt_reg + idx_t'(1);
      if (init_cnt_reg == idx_t'(N_ENT - 1)) state_next = ST_RUN;
    end
  end

  // Grants and valid-vector update; all grants are combinational.
  always_comb begin
    is_run    = (state_reg == ST_RUN);
    alloc_gnt = cl.alloc_req & free_any & is_run;
    // A read may not target the entry that the alloc writes this cycle.
    rd_gnt    = cl.rd_req & is_run & ~(alloc_gnt & (cl.rd_idx == free_idx));
`ifdef MB_CAM_CTL_LKBYP_EN
    lk_gnt    = cl.lk_req & is_run;
`else
    // CAM match outputs are undefined while any row is being written.
    lk_gnt    = cl.lk_req & is_run & ~alloc_gnt;
`endif
    valid_next = valid_reg;
    // Free first, then set: an alloc always targets an already-invalid slot,
    // so a dealloc naming that slot is a no-op and must not undo the alloc.
    if (cl.dealloc_vld) valid_next[cl.dealloc_idx] = 1'b0;
    if (alloc_gnt)      valid_next[free_idx]       = 1'b1;
  end

  // Outputs: state decode, CAM command bus and client responses.
  always_comb begin
    // The sweep write is held off while reset is asserted.
    init_wr       = (state_reg == ST_INIT) & rst_l;
    cl.busy       = (state_reg == ST_INIT);
    cl.full       = ~free_any;

    cam_write_en  = init_wr | alloc_gnt;
    cam_adr_w     = '0;
    cam_din       = '0;
    if (init_wr) begin
      cam_adr_w = onehot(init_cnt_reg);
      cam_din   = INIT_DATA;
    end else if (alloc_gnt) begin
      cam_adr_w = onehot(free_idx);
      cam_din   = cl.alloc_din;
    end

    cam_read_en   = rd_gnt;
    cam_adr_r     = rd_gnt ? onehot(cl.rd_idx) : '0;
    cam_lookup_en = lk_gnt;
    cam_key       = lk_gnt ? cl.lk_key : '0;

    cl.alloc_gnt  = alloc_gnt;
    cl.alloc_idx  = alloc_gnt ? free_idx : '0;
    cl.rd_gnt     = rd_gnt;
    cl.rd_vld     = rd_vld_reg;
    cl.rd_data    = rd_data_reg;
    cl.lk_gnt     = lk_gnt;
    cl.lk_vld     = lk_vld_reg;
    cl.lk_hit     = lk_hit_reg;
    cl.lk_hit_idx = lk_hit_idx_reg;
    cl.lk_multi   = lk_multi_reg;
  end

  // Match qualification in the cycle after the lookup grant, using the
  // valid bits of that cycle so entries freed meanwhile do not report hits.
  for (genvar gi = 0; gi < N_ENT; gi++) begin : g_qual
`ifdef MB_CAM_CTL_LKBYP_EN
    // The row written alongside the lookup is compared from captured data.
    assign qual_match[gi] = valid_reg[gi] &
                            ((byp_vld_reg && (byp_slot_reg == idx_t'(gi))) ?
                             (byp_key_reg == lk_key_reg) : cam_match[gi]);
`else
    assign qual_match[gi] = valid_reg[gi] & cam_match[gi];
`endif
  end

  // Read and lookup pipelines: grant in N, CAM output in N+1, result in N+2.
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      rd_p1_reg      <= 1'b0;
      rd_vld_reg     <= 1'b0;
      rd_data_reg    <= '0;
      lk_p1_reg      <= 1'b0;
      lk_vld_reg     <= 1'b0;
      lk_hit_reg     <= 1'b0;
      lk_hit_idx_reg <= '0;
      lk_multi_reg   <= 1'b0;
    end else begin
      rd_p1_reg      <= rd_gnt;
      rd_vld_reg     <= rd_p1_reg;
      rd_data_reg    <= rd_p1_reg ? cam_dout : '0;
      lk_p1_reg      <= lk_gnt;
      lk_vld_reg     <= lk_p1_reg;
      lk_hit_reg     <= lk_p1_reg & hit_any;
      lk_hit_idx_reg <= lk_p1_reg ? hit_idx : '0;
      lk_multi_reg   <= lk_p1_reg & hit_multi;
    end
  end

`ifdef MB_CAM_CTL_LKBYP_EN
  // Capture the alloc key and lookup key for a lookup granted during a write.
  always_ff @(posedge rclk or negedge rst_l) begin
    if (!rst_l) begin
      byp_vld_reg  <= 1'b0;
      byp_slot_reg <= '0;
      byp_key_reg  <= '0;
      lk_key_reg   <= '0;
    end else begin
      byp_vld_reg  <= lk_gnt & alloc_gnt;
      byp_slot_reg <= free_idx;
      byp_key_reg  <= cl.alloc_din[KEY_HI:KEY_LO];
      lk_key_reg   <= cl.lk_key;
    end
  end
`endif

endmodule

// File: tb/tb_mb_cam_ctl.sv
// Directed bench for mb_cam_ctl with a behavioural CAM (registered read and
// match). Expectations follow the MB_CAM_CTL_LKBYP_EN setting of the build.
module tb_mb_cam_ctl;

`ifdef MB_CAM_CTL_LKBYP_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        rclk = 1'b0;
  logic        rst_l = 1'b0;

  logic        cam_write_en;
  logic [15:0] cam_adr_w;
  logic [39:0] cam_din;
  logic        cam_read_en;
  logic [15:0] cam_adr_r;
  logic        cam_lookup_en;
  logic [39:8] cam_key;
  logic [39:0] cam_dout = '0;
  logic [15:0] cam_match = '0;

  mb_cam_ctl_if bus ();

  mb_cam_ctl #(.INIT_DATA(40'h0)) dut (
    .rclk          (rclk),
    .rst_l         (rst_l),
    .cl            (bus),
    .cam_write_en  (cam_write_en),
    .cam_adr_w     (cam_adr_w),
    .cam_din       (cam_din),
    .cam_read_en   (cam_read_en),
    .cam_adr_r     (cam_adr_r),
    .cam_lookup_en (cam_lookup_en),
    .cam_key       (cam_key),
    .cam_dout      (cam_dout),
    .cam_match     (cam_match)
  );

  always #5 rclk = ~rclk;

  // Behavioural CAM: old contents are seen by reads/lookups on a write edge.
  logic [39:0] cam_mem [16];
  always @(posedge rclk) begin
    for (int i = 0; i < 16; i++) begin
      if (cam_write_en && cam_adr_w[i]) cam_mem[i] <= cam_din;
      if (cam_lookup_en) cam_match[i] <= (cam_mem[i][39:8] == cam_key);
      if (cam_read_en && cam_adr_r[i]) cam_dout <= cam_mem[i];
    end
  end

  typedef struct packed {
    logic        a_req;
    logic [39:0] a_din;
    logic        d_vld;
    logic [3:0]  d_idx;
    logic        r_req;
    logic [3:0]  r_idx;
    logic        l_req;
    logic [31:0] l_key;
    logic        e_agnt;
    logic [3:0]  e_aidx;
    logic        e_full;
    logic        e_rgnt;
    logic        e_rvld;
    logic [39:0] e_rdata;
    logic        e_lgnt;
    logic        e_lvld;
    logic        e_lhit;
    logic [3:0]  e_lidx;
    logic        e_lmulti;
  } row_t;

  localparam int NV = 28;
  row_t tv [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] dval(input int k);
    if (k == 2) return {32'hDEADBEEF, 8'h02};
    if (k == 7) return {32'hDEADBEEF, 8'h07};
    return {32'hA0000000 + 32'(k), 8'(k)};
  endfunction

  task automatic drive(input row_t v);
    bus.alloc_req   = v.a_req;
    bus.alloc_din   = v.a_din;
    bus.dealloc_vld = v.d_vld;
    bus.dealloc_idx = v.d_idx;
    bus.rd_req      = v.r_req;
    bus.rd_idx      = v.r_idx;
    bus.lk_req      = v.l_req;
    bus.lk_key      = v.l_key;
  endtask

  task automatic idle();
    row_t z;
    z = '0;
    drive(z);
  endtask

  initial begin
    logic [15:0] exp_w;

    // ---- vector table ----
    for (int k = 0; k < NV; k++) tv[k] = '0;
    for (int k = 0; k < 16; k++) begin
      tv[k].a_req  = 1'b1;
      tv[k].a_din  = dval(k);
      tv[k].e_agnt = 1'b1;
      tv[k].e_aidx = 4'(k);
    end
    // read of the slot being allocated is refused, retry succeeds
    tv[3].r_req = 1'b1; tv[3].r_idx = 4'd3; tv[3].e_rgnt = 1'b0;
    tv[4].r_req = 1'b1; tv[4].r_idx = 4'd3; tv[4].e_rgnt = 1'b1;
    tv[5].r_req = 1'b1; tv[5].r_idx = 4'd0; tv[5].e_rgnt = 1'b1;
    tv[6].e_rvld = 1'b1; tv[6].e_rdata = dval(3);
    tv[7].e_rvld = 1'b1; tv[7].e_rdata = dval(0);
    // full: alloc refused, lookup of the duplicated key
    tv[16].a_req = 1'b1; tv[16].a_din = 40'h11; tv[16].e_full = 1'b1;
    tv[16].l_req = 1'b1; tv[16].l_key = 32'hDEADBEEF; tv[16].e_lgnt = 1'b1;
    tv[17].a_req = 1'b1; tv[17].d_vld = 1'b1; tv[17].d_idx = 4'd5; tv[17].e_full = 1'b1;
    tv[18].a_req = 1'b1; tv[18].a_din = 40'h55_5555_5505;
    tv[18].e_agnt = 1'b1; tv[18].e_aidx = 4'd5;
    tv[18].e_lvld = 1'b1; tv[18].e_lhit = 1'b1; tv[18].e_lidx = 4'd2; tv[18].e_lmulti = 1'b1;
    tv[19].a_req = 1'b1; tv[19].e_full = 1'b1; tv[19].d_vld = 1'b1; tv[19].d_idx = 4'd2;
    tv[20].l_req = 1'b1; tv[20].l_key = 32'hDEADBEEF; tv[20].e_lgnt = 1'b1;
    // lookup concurrent with alloc of a matching key into slot 2
    tv[22].e_lvld = 1'b1; tv[22].e_lhit = 1'b1; tv[22].e_lidx = 4'd7;
    tv[22].a_req = 1'b1; tv[22].a_din = {32'hCAFEF00D, 8'h22};
    tv[22].e_agnt = 1'b1; tv[22].e_aidx = 4'd2;
    tv[22].l_req = 1'b1; tv[22].l_key = 32'hCAFEF00D; tv[22].e_lgnt = BYP;
    tv[23].e_full = 1'b1; tv[23].l_req = 1'b1; tv[23].l_key = 32'hCAFEF00D; tv[23].e_lgnt = 1'b1;
    tv[24].e_full = 1'b1;
    tv[24].e_lvld = BYP; tv[24].e_lhit = BYP; tv[24].e_lidx = 4'd2;
    tv[25].e_full = 1'b1; tv[25].e_lvld = 1'b1; tv[25].e_lhit = 1'b1; tv[25].e_lidx = 4'd2;
    tv[25].l_req = 1'b1; tv[25].l_key = 32'h12345678; tv[25].e_lgnt = 1'b1;
    tv[26].e_full = 1'b1;
    tv[27].e_full = 1'b1; tv[27].e_lvld = 1'b1;

    // ---- reset state ----
    idle();
    bus.alloc_req = 1'b1;
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    chk("rst_busy", bus.busy, 1);
    chk("rst_wen", cam_write_en, 0);
    chk("rst_agnt", bus.alloc_gnt, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_rvld", bus.rd_vld, 0);
    chk("rst_lvld", bus.lk_vld, 0);
    $display("[TB] reset: busy=%0b wen=%0b", bus.busy, cam_write_en);

    // ---- INIT sweep ----
    @(posedge rclk); #1;
    rst_l = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge rclk);
      exp_w = 16'h0001 << k;
      chk("init_busy", bus.busy, 1);
      chk("init_wen", cam_write_en, 1);
      chk("init_adr_w", cam_adr_w, exp_w);
      chk("init_din", cam_din, 0);
      chk("init_agnt", bus.alloc_gnt, 0);
      $display("[TB] init %0d: adr_w=%04h din=%0h busy=%0b", k, cam_adr_w, cam_din, bus.busy);
      @(posedge rclk); #1;
    end
    bus.alloc_req = 1'b0;
    @(negedge rclk);
    chk("run_busy", bus.busy, 0);
    chk("run_wen", cam_write_en, 0);
    @(posedge rclk); #1;

    // ---- table-driven run ----
    for (int k = 0; k < NV; k++) begin
      drive(tv[k]);
      @(negedge rclk);
      chk($sformatf("r%0d_agnt", k), bus.alloc_gnt, tv[k].e_agnt);
      if (tv[k].e_agnt) chk($sformatf("r%0d_aidx", k), bus.alloc_idx, tv[k].e_aidx);
      chk($sformatf("r%0d_full", k), bus.full, tv[k].e_full);
      chk($sformatf("r%0d_rgnt", k), bus.rd_gnt, tv[k].e_rgnt);
      chk($sformatf("r%0d_rvld", k), bus.rd_vld, tv[k].e_rvld);
      if (tv[k].e_rvld) chk($sformatf("r%0d_rdata", k), bus.rd_data, tv[k].e_rdata);
      chk($sformatf("r%0d_lgnt", k), bus.lk_gnt, tv[k].e_lgnt);
      chk($sformatf("r%0d_lvld", k), bus.lk_vld, tv[k].e_lvld);
      if (tv[k].e_lvld) begin
        chk($sformatf("r%0d_lhit", k), bus.lk_hit, tv[k].e_lhit);
        chk($sformatf("r%0d_lidx", k), bus.lk_hit_idx, tv[k].e_lidx);
        chk($sformatf("r%0d_lmulti", k), bus.lk_multi, tv[k].e_lmulti);
      end
      chk($sformatf("r%0d_busy", k), bus.busy, 0);
      $display("[TB] row %0d: agnt=%0b aidx=%0d full=%0b rgnt=%0b rvld=%0b rdata=%0h lgnt=%0b lvld=%0b hit=%0b hidx=%0d multi=%0b",
               k, bus.alloc_gnt, bus.alloc_idx, bus.full, bus.rd_gnt, bus.rd_vld, bus.rd_data,
               bus.lk_gnt, bus.lk_vld, bus.lk_hit, bus.lk_hit_idx, bus.lk_multi);
      @(posedge rclk); #1;
    end

    // ---- asynchronous reset with a read in flight ----
    idle();
    bus.rd_req = 1'b1;
    bus.rd_idx = 4'd0;
    @(negedge rclk);
    chk("flight_rgnt", bus.rd_gnt, 1);
    @(posedge rclk); #1;
    idle();
    #2 rst_l = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1);
    chk("arst_full", bus.full, 0);
    chk("arst_wen", cam_write_en, 0);
    chk("arst_rvld", bus.rd_vld, 0);
    $display("[TB] async reset: busy=%0b full=%0b rvld=%0b", bus.busy, bus.full, bus.rd_vld);
    @(posedge rclk); #1;
    rst_l = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge rclk);
      chk("drop_rvld", bus.rd_vld, 0);
      chk("drop_busy", bus.busy, 1);
      @(posedge rclk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
